rgmii_rx: RTL and testbench
===========================

# rgmii_rx

Receive-side RGMII framer for the 125 MHz point-to-point link. It deserialises DDR nibbles into bytes and parses our fixed-format frame: preamble/SFD, 6-byte destination MAC, 6-byte source, ethertype 0x1919, 16-bit sequence number, 1024 payload bytes and FCS. It writes the payload into one half of a double-buffered packet RAM and, after a CRC-checked good frame, toggles `rxidx` so downstream logic reads the completed half. It is the peer of the `tx` frame generator.

## Interface
- `MYMAC`, default 48'h0088dab8bf08: accepted destination address. Byte k is `MYMAC[8k+7:8k]`, and byte 0 is on the wire first.
- `ETYPE`, default 16'h1919: required ethertype. Low byte is first on the wire.
- `clk125`  in  1  125 MHz RGMII receive clock. This is the only clock. Both edges sample `rxd`/`rxctl`.
- `rst`  in  1  reset, asynchronous and active-high.
- `rxctl`  in  1  RGMII control. The posedge sample is DV. The negedge sample is DV^ER.
- `rxd`  in  4  RGMII data. The posedge sample is the low nibble; the negedge sample is the high nibble.
- `rxwe`  out  1  payload RAM write strobe.
- `rxad`  out  11  RAM address `{~rxidx, offset[9:0]}`.
- `rxdata`  out  8  payload byte.
- `rxidx`  out  1  buffer holding the newest good frame. Toggles once per good frame.
- `rxgood`  out  1  one-cycle pulse when a good frame is committed.
- `rxseq`  out  16  sequence number of the last good frame.
- `goodcnt`, `badcnt`, `seqerr`  out  16 each  counters. Each wraps modulo 2^16.

## Operation
- Byte assembly: the posedge nibble and the following negedge nibble form byte `{hi,lo}`, which is valid at the next posedge. `dv` is the posedge `rxctl`. `er` is posedge `rxctl` XOR negedge `rxctl`.
- Byte index n counts from the first byte after SFD. n=0..5 is DMAC, 6..11 SMAC (ignored), 12..13 ETYPE, 14..15 seq (low byte first), 16..1039 payload, 1040..1043 FCS.
- CRC: reflected CRC-32 with polynomial 0xEDB88320 and init 0xFFFFFFFF, computed over bytes 0..1043 including FCS. The frame passes only if the residue is 0xDEBB20E3.
- States:
  - WAIT: waits until dv=0, then goes to IDLE. This is the reset state.
  - IDLE: dv=1 with byte 0x55 goes to PRE. Any other dv=1 byte goes to DROP.
  - PRE: 0x55 stays in PRE. 0xD5 goes to HDR with n=0 and the CRC initialised. Any other byte goes to DROP.
  - HDR, n=0..15: a DMAC byte ≠ MYMAC or an ETYPE byte ≠ ETYPE goes to DROP. This is not counted as bad, because the frame is not ours. Seq bytes are latched into a staging register. n=15 goes to DATA.
  - DATA, n=16..1039: each byte issues a write with offset n-16. n=1039 goes to FCS.
  - FCS, n=1040..1043: after n=1043 goes to CHK.
  - CHK: lasts one cycle. The frame is good if the residue matches, dv=0 in this cycle (no extra byte), and no er was seen since SFD.
    - If good: toggle `rxidx`, pulse `rxgood`, load `rxseq`, and increment `goodcnt`. If `rxseq` has been loaded at least once and the staged seq ≠ `rxseq`+1 (mod 2^16), increment `seqerr`.
    - If not good: increment `badcnt`.
    - Next state is WAIT if dv=1, else IDLE.
  - DROP: waits for dv=0, then goes to IDLE.
- Truncation: dv falling in HDR (once DMAC/ETYPE have matched), DATA or FCS increments `badcnt` and goes to IDLE. The RAM half `~rxidx` may then hold partial data; `rxidx` is unchanged.
- Bad frames never toggle `rxidx`. The next frame overwrites the same half.
- Reset values: `rxwe`=0, `rxad`=0, `rxdata`=0, `rxidx`=0, `rxgood`=0, `rxseq`=0, all counters 0. The seq-valid flag is cleared and the state is WAIT.

## Timing
- Nibbles of byte k arrive in cycle c (posedge c and the following negedge). The byte is decoded at posedge c+1. `rxwe`/`rxad`/`rxdata` for that byte are registered outputs, high during cycle c+2.
- Payload writes occur on 1024 consecutive cycles with no gaps. Offsets run 0..1023 in order.
- Last FCS byte arrives in cycle m. CHK is evaluated in cycle m+1. `rxidx`, `rxseq`, the counters and the `rxgood` pulse update at posedge m+2.
- The last RAM write (cycle m-2) precedes the `rxidx` toggle by 4 cycles.
- Asynchronous reset mid-frame clears outputs immediately. After release, the block stays in WAIT until dv=0, so it never accepts a partial frame.
- An er in any cycle marks the frame bad but does not abort writes.

## Test plan
- Good frame: 7×0x55, 0xD5, DMAC 08 bf b8 da 88 00, SMAC 6×0x66, 19 19, seq 34 12, payload byte i = i[7:0], correct FCS -> 1024 writes at `rxad` 0x400..0x7FF with data i, `rxidx` 0→1, `rxseq`=0x1234, `goodcnt`=1, one `rxgood` pulse.
- Same frame with one payload bit flipped -> writes occur, `rxidx` stays 0, `badcnt`=1, `goodcnt`=0.
- DMAC byte 0 = 0x09 -> no writes, all counters unchanged. A following good frame is accepted normally.
- Good frames with seq 5, 6, 8 -> `goodcnt`=3, `seqerr`=1, `rxidx` toggles 3 times and ends at 1. Also check seq 0xFFFF followed by 0x0000 -> no `seqerr`.
- dv dropped after payload byte 500 -> `badcnt`=1, IDLE. The next good frame writes to 0x400 half again and `rxidx`→1.
- Assert `rst` during DATA while dv stays high for 200 more cycles -> outputs zero, no writes and no count until dv=0. The next full frame is good.

Source files
------------

// File: rtl/rgmii_rx.sv
// RGMII receive framer: rebuilds bytes from DDR nibbles, parses the fixed frame,
// writes the payload into the idle half of a double-buffered RAM and commits it on a good FCS.
module rgmii_rx #(
  parameter logic [47:0] MYMAC = 48'h0088dab8bf08,
  parameter logic [15:0] ETYPE = 16'h1919
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic        rxctl,
  input  logic [3:0]  rxd,
  output logic        rxwe,
  output logic [10:0] rxad,
  output logic [7:0]  rxdata,
  output logic        rxidx,
  output logic        rxgood,
  output logic [15:0] rxseq,
  output logic [15:0] goodcnt,
  output logic [15:0] badcnt,
  output logic [15:0] seqerr,
  output logic [2:0]  state
);

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_CHK  = 3'd6;
  localparam logic [2:0] S_DROP = 3'd7;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [3:0]  lo_q, hi_q;
  logic        dvp_q, ctln_q;
  logic [7:0]  byte_in;
  logic        dv, er;
  logic [10:0] n;
  logic [31:0] crc;
  logic        er_seen;
  logic [15:0] seq_stage;
  logic        seq_valid;
  logic        wr_pend;
  logic [9:0]  wr_off;
  logic [7:0]  wr_data;
  logic [7:0]  mac_byte;
  logic        hdr_bad;
  logic        chk_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // dv resets high so a frame in progress at reset release is waited out in WAIT.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      lo_q  <= 4'h0;
      dvp_q <= 1'b1;
    end else begin
      lo_q  <= rxd;
      dvp_q <= rxctl;
    end
  end

  always_ff @(negedge clk125 or posedge rst) begin
    if (rst) begin
      hi_q   <= 4'h0;
      ctln_q <= 1'b1;
    end else begin
      hi_q   <= rxd;
      ctln_q <= rxctl;
    end
  end

  assign byte_in  = {hi_q, lo_q};
  assign dv       = dvp_q;
  assign er       = dvp_q ^ ctln_q;
  assign mac_byte = MYMAC[{n[2:0], 3'b000} +: 8];
  assign hdr_bad  = ((n < 11'd6) && (byte_in != mac_byte)) ||
                    ((n == 11'd12) && (byte_in != ETYPE[7:0])) ||
                    ((n == 11'd13) && (byte_in != ETYPE[15:8]));
  assign chk_good = (crc == CRC_RESIDUE) && !dv && !er_seen && !er;

  // Valid/ready: none; each byte slot is consumed unconditionally, rxwe is a one-cycle write strobe.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      n         <= 11'd0;
      crc       <= 32'hFFFFFFFF;
      er_seen   <= 1'b0;
      seq_stage <= 16'h0;
      seq_valid <= 1'b0;
      wr_pend   <= 1'b0;
      wr_off    <= 10'd0;
      wr_data   <= 8'h00;
      rxwe      <= 1'b0;
      rxad      <= 11'd0;
      rxdata    <= 8'h00;
      rxidx     <= 1'b0;
      rxgood    <= 1'b0;
      rxseq     <= 16'h0;
      goodcnt   <= 16'h0;
      badcnt    <= 16'h0;
      seqerr    <= 16'h0;
    end else begin
      wr_pend <= 1'b0;
      rxgood  <= 1'b0;
      rxwe    <= wr_pend;
      if (wr_pend) begin
        rxad   <= {~rxidx, wr_off};
        rxdata <= wr_data;
      end
      case (state)
        S_WAIT: if (!dv) state <= S_IDLE;
        S_IDLE: if (dv) state <= (byte_in == 8'h55) ? S_PRE : S_DROP;
        S_PRE: begin
          if (!dv) state <= S_IDLE;
          else if (byte_in == 8'hD5) begin
            state   <= S_HDR;
            n       <= 11'd0;
            crc     <= 32'hFFFFFFFF;
            er_seen <= 1'b0;
          end else if (byte_in != 8'h55) state <= S_DROP;
        end
        S_HDR: begin
          if (!dv) begin
            if (n >= 11'd14) badcnt <= badcnt + 16'd1;
            state <= S_IDLE;
          end else if (hdr_bad) begin
            state <= S_DROP;
          end else begin
            crc     <= crc_byte(crc, byte_in);
            n       <= n + 11'd1;
            er_seen <= er_seen | er;
            if (n == 11'd14) seq_stage[7:0] <= byte_in;
            if (n == 11'd15) begin
              seq_stage[15:8] <= byte_in;
              state           <= S_DATA;
            end
          end
        end
        S_DATA, S_FCS: begin
          if (!dv) begin
            badcnt <= badcnt + 16'd1;
            state  <= S_IDLE;
          end else begin
            crc     <= crc_byte(crc, byte_in);
            n       <= n + 11'd1;
            er_seen <= er_seen | er;
            if (state == S_DATA) begin
              wr_pend <= 1'b1;
              wr_off  <= n[9:0] - 10'd16;
              wr_data <= byte_in;
              if (n == 11'd1039) state <= S_FCS;
            end else if (n == 11'd1043) begin
              state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (chk_good) begin
            rxidx     <= ~rxidx;
            rxgood    <= 1'b1;
            rxseq     <= seq_stage;
            seq_valid <= 1'b1;
            goodcnt   <= goodcnt + 16'd1;
            if (seq_valid && (seq_stage != rxseq + 16'd1)) seqerr <= seqerr + 16'd1;
          end else begin
            badcnt <= badcnt + 16'd1;
          end
          state <= dv ? S_WAIT : S_IDLE;
        end
        default: if (!dv) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx.sv
// Bench for rgmii_rx: random frames against a frame-level reference model, with a
// scoreboard of expected RAM writes and good-frame commits popped by a monitor.
module tb_rgmii_rx;

  localparam logic [47:0] MYMAC = 48'h0088dab8bf08;

  logic        clk125 = 1'b0;
  logic        rst;
  logic        rxctl;
  logic [3:0]  rxd;
  logic        rxwe;
  logic [10:0] rxad;
  logic [7:0]  rxdata;
  logic        rxidx;
  logic        rxgood;
  logic [15:0] rxseq;
  logic [15:0] goodcnt, badcnt, seqerr;
  logic [2:0]  state;

  rgmii_rx dut (
    .clk125(clk125), .rst(rst), .rxctl(rxctl), .rxd(rxd),
    .rxwe(rxwe), .rxad(rxad), .rxdata(rxdata), .rxidx(rxidx),
    .rxgood(rxgood), .rxseq(rxseq), .goodcnt(goodcnt), .badcnt(badcnt),
    .seqerr(seqerr), .state(state)
  );

  // clock / reset
  always #4 clk125 = ~clk125;

  int n_checks = 0;
  int n_pass   = 0;

  logic [18:0] exp_q[$];       // {addr, data}
  logic [16:0] exp_good_q[$];  // {rxidx, rxseq}
  logic [7:0]  fr[$];
  bit          pay_inc;

  // reference model state
  logic        m_idx;
  logic [15:0] m_seq;
  bit          m_seq_valid;
  int          m_good, m_bad, m_seqerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor
  always @(negedge clk125) begin
    if (!rst && rxwe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", rxad, rxdata);
      end else begin
        check("ram_write", {13'h0, rxad, rxdata}, {13'h0, exp_q.pop_front()});
      end
    end
    if (!rst && rxgood) begin
      if (exp_good_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rxgood: got seq %0h expected none", rxseq);
      end else begin
        check("good_commit", {15'h0, rxidx, rxseq}, {15'h0, exp_good_q.pop_front()});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive(input logic [7:0] b, input logic dv);
    @(negedge clk125); #1;
    rxd = b[3:0]; rxctl = dv;
    @(posedge clk125); #1;
    rxd = b[7:4]; rxctl = dv;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) drive(8'h00, 1'b0);
  endtask

  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < len; k++) begin
      c = c ^ {24'h0, fr[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [15:0] seq);
    logic [31:0] fcs;
    logic [7:0]  pb;
    fr = {};
    for (int k = 0; k < 6; k++) fr.push_back(dmac[8*k +: 8]);
    for (int k = 0; k < 6; k++) fr.push_back(8'h66);
    fr.push_back(8'h19); fr.push_back(8'h19);
    fr.push_back(seq[7:0]); fr.push_back(seq[15:8]);
    for (int k = 0; k < 1024; k++) begin
      pb = pay_inc ? k[7:0] : 8'($urandom);
      fr.push_back(pb);
    end
    fcs = fcs_of(1040);
    for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
  endtask

  task automatic preamble();
    int p;
    p = $urandom_range(1, 7);
    for (int k = 0; k < p; k++) drive(8'h55, 1'b1);
    drive(8'hD5, 1'b1);
  endtask

  // trunc < 0: full frame; otherwise only payload bytes 0..trunc-1 are sent
  task automatic send_frame(input logic [47:0] dmac, input logic [15:0] seq, input bit flip, input int trunc);
    bit ours, good;
    int npay, last;
    logic [9:0] off;
    build(dmac, seq);
    if (flip) fr[16 + $urandom_range(0, 1023)] ^= (8'h01 << $urandom_range(0, 7));
    ours = (dmac == MYMAC);
    good = ours && (trunc < 0) && (fcs_of(1040) == {fr[1043], fr[1042], fr[1041], fr[1040]});
    npay = !ours ? 0 : ((trunc < 0) ? 1024 : trunc);
    for (int k = 0; k < npay; k++) begin
      off = k[9:0];
      exp_q.push_back({~m_idx, off, fr[16+k]});
    end
    if (good) begin
      if (m_seq_valid && (seq != m_seq + 16'd1)) m_seqerr++;
      m_seq = seq;
      m_seq_valid = 1;
      m_idx = ~m_idx;
      m_good++;
      exp_good_q.push_back({m_idx, seq});
    end else if (ours) begin
      m_bad++;
    end
    last = (trunc < 0) ? 1043 : 15 + trunc;
    preamble();
    for (int k = 0; k <= last; k++) drive(fr[k], 1'b1);
    idle($urandom_range(6, 12));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_goodcnt"}, {16'h0, goodcnt}, m_good);
    check({tag, "_badcnt"}, {16'h0, badcnt}, m_bad);
    check({tag, "_seqerr"}, {16'h0, seqerr}, m_seqerr);
    check({tag, "_rxidx"}, {31'h0, rxidx}, {31'h0, m_idx});
    check({tag, "_rxseq"}, {16'h0, rxseq}, {16'h0, m_seq});
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_commits_left"}, exp_good_q.size(), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_good_q.delete();
    m_idx = 1'b0; m_seq = 16'h0; m_seq_valid = 0;
    m_good = 0; m_bad = 0; m_seqerr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxwe"}, {31'h0, rxwe}, 0);
    check({tag, "_rxad"}, {21'h0, rxad}, 0);
    check({tag, "_rxdata"}, {24'h0, rxdata}, 0);
    check({tag, "_rxidx"}, {31'h0, rxidx}, 0);
    check({tag, "_rxgood"}, {31'h0, rxgood}, 0);
    check({tag, "_rxseq"}, {16'h0, rxseq}, 0);
    check({tag, "_counters"}, {goodcnt, badcnt ^ seqerr}, 0);
  endtask

  initial begin
    rst = 1'b1; rxctl = 1'b0; rxd = 4'h0;
    model_reset();
    #20;
    check_reset_outputs("reset");
    @(negedge clk125); rst = 1'b0;
    idle(4);

    pay_inc = 1;
    send_frame(MYMAC, 16'h1234, 0, -1);
    check_model("good");
    send_frame(MYMAC, 16'h1235, 1, -1);
    check_model("bitflip");
    send_frame({MYMAC[47:8], 8'h09}, 16'h1236, 0, -1);
    check_model("foreign_dmac");
    send_frame(MYMAC, 16'h1236, 0, -1);
    check_model("after_foreign");

    pay_inc = 0;
    send_frame(MYMAC, 16'd5, 0, -1);
    send_frame(MYMAC, 16'd6, 0, -1);
    send_frame(MYMAC, 16'd8, 0, -1);
    check_model("seq_gap");
    send_frame(MYMAC, 16'hFFFF, 0, -1);
    send_frame(MYMAC, 16'h0000, 0, -1);
    check_model("seq_wrap");

    send_frame(MYMAC, 16'h0001, 0, 501);
    check_model("truncated");
    send_frame(MYMAC, 16'h0002, 0, -1);
    check_model("after_trunc");

    // reset in the middle of the payload while dv stays high
    build(MYMAC, 16'h00AA);
    for (int k = 0; k < 100; k++) exp_q.push_back({~m_idx, k[9:0], fr[16+k]});
    preamble();
    for (int k = 0; k < 116; k++) drive(fr[k], 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midframe_reset");
    drive(fr[116], 1'b1);
    drive(fr[117], 1'b1);
    rst = 1'b0;
    for (int k = 118; k < 318; k++) drive(fr[k], 1'b1);
    idle(8);
    check_model("post_reset_flush");
    send_frame(MYMAC, 16'h00AB, 0, -1);
    check_model("post_reset_good");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
